// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the fetch-queue entry type used by the fetch front end.
package pipeline_pkg;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;

  localparam logic [PC_W-1:0]   DEFAULT_RESET_PC = 32'h0040_0000;
  localparam logic [PC_W-1:0]   PC_STEP          = 32'd4;
  localparam logic [INST_W-1:0] NOP_INST         = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch front-end bundle: instruction-memory request/return, decode redirect and decode handshake.
interface inst_fetch_queue_if;
  import pipeline_pkg::*;

  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic [INST_W-1:0] imem_rdata;
  logic              isbranch;
  logic [PC_W-1:0]   branch_pc;
  logic              id_ready;
  logic              if_valid;
  logic [PC_W-1:0]   if_pc_out;
  logic [INST_W-1:0] if_inst_out;

  modport master (
    output imem_req, imem_addr, if_valid, if_pc_out, if_inst_out,
    input  imem_rdata, isbranch, branch_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc_out, if_inst_out,
    output imem_rdata, isbranch, branch_pc, id_ready
  );

endinterface

// File: rtl/inst_fetch_queue_fifo.sv
// fetch_fifo: synchronous DEPTH-entry FIFO of {pc, inst} with flush; flush wins over push/pop.
module fetch_fifo
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  fetch_entry_t    mem_d [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign full      = (count_q == FULL_COUNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front end: PC, single outstanding imem request and a fetch queue toward decode.
// Optional build macro IF_PERF_EN adds perf_fetched/perf_flushed saturating counters.
module inst_fetch_queue
  import pipeline_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  inst_fetch_queue_if.master bus
`ifdef IF_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_flushed
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;

  fetch_entry_t    fifo_head;
  fetch_entry_t    fifo_push_data;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            pop;
  logic            issue;
  logic [CW-1:0]   occupancy;

  // A redirect suppresses both the pop and the request in its own cycle.
  assign pop       = !fifo_empty && bus.id_ready && !bus.isbranch && !reset;
  assign occupancy = fifo_count + {{(CW-1){1'b0}}, inflight_q} - {{(CW-1){1'b0}}, pop};
  assign issue     = !reset && !bus.isbranch && !(fifo_full && !pop) && (occupancy < DEPTH_C);

  assign fifo_push      = inflight_q && !bus.isbranch;
  assign fifo_push_data = '{pc: inflight_pc_q, inst: bus.imem_rdata};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (pop),
    .flush     (bus.isbranch),
    .head_data (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (bus.isbranch) begin
      pc_d = align_pc(bus.branch_pc);
    end else if (issue) begin
      pc_d          = pc_q + PC_STEP;
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = pc_q;
  assign bus.if_valid    = !fifo_empty;
  assign bus.if_pc_out   = fifo_empty ? '0 : fifo_head.pc;
  assign bus.if_inst_out = fifo_empty ? NOP_INST : fifo_head.inst;

`ifdef IF_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;
  logic [32:0] flushed_sum;

  assign flushed_sum = {1'b0, perf_flushed_q} + 33'(fifo_count) + 33'(inflight_q);

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_flushed_d = perf_flushed_q;
    if (pop && perf_fetched_q != 32'hFFFF_FFFF) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    if (bus.isbranch) begin
      perf_flushed_d = flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif

endmodule
